// File: rtl/slink_fifo_rd_stream.sv
// slink_fifo_rd_stream
//   Read-side adapter that sits directly on the async FIFO read port, in the
//   read clock domain. It turns the FIFO's combinational rempty/rinc/rdata
//   interface into a registered valid/ready stream. A two-entry skid buffer
//   (head + tail) keeps throughput at one word per cycle while out_data
//   comes straight from a register.
//
// Ports
//   clk          read-domain clock (same as FIFO read side)
//   reset        synchronous, active-high reset
//   enable       1: new FIFO pops allowed; 0: no pops, buffer still drains
//   flush        single-cycle pulse, discards all buffered words
//   fifo_rempty  FIFO empty flag
//   fifo_rdata   FIFO head word, valid whenever fifo_rempty=0
//   fifo_rinc    FIFO pop strobe
//   out_valid    stream word available
//   out_ready    downstream accepts the word
//   out_data     stream word (registered head entry)
//   buf_count    number of buffered words (0..2)
//   idle         buffer empty and FIFO empty
//   word_cnt     (only with SLINK_FIFO_RD_STREAM_CNT_EN) saturating count of
//                delivered words, cleared by reset and flush
//
// Optional feature macro: SLINK_FIFO_RD_STREAM_CNT_EN

module slink_fifo_rd_stream #(
  parameter int DATA_SIZE = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_rempty,
  input  logic [DATA_SIZE-1:0] fifo_rdata,
  output logic                 fifo_rinc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [1:0]           buf_count,
  output logic                 idle
`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]          word_cnt
`endif
);

  logic [DATA_SIZE-1:0] head_p0;
  logic [DATA_SIZE-1:0] tail_p0;
  logic [1:0]           count_p0;
  logic                 push;
  logic                 take;

  // Pop decision uses only registered state and inputs; there is deliberately
  // no path from out_ready, so the FIFO read side never waits on downstream.
  assign fifo_rinc = ~reset & ~flush & enable & ~fifo_rempty & (count_p0 != 2'd2);
  assign push      = fifo_rinc;
  assign out_valid = (count_p0 != 2'd0);
  assign take      = out_valid & out_ready;
  assign out_data  = head_p0;
  assign buf_count = count_p0;
  assign idle      = (count_p0 == 2'd0) & fifo_rempty;

  // ---- Stage p0: skid buffer (head/tail entries + occupancy) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p0 <= 2'd0;
      head_p0  <= '0;
      tail_p0  <= '0;
    end else if (flush) begin
      // Entries keep stale contents; only occupancy matters.
      count_p0 <= 2'd0;
    end else begin
      case (count_p0)
        2'd0: begin
          if (push) begin
            head_p0  <= fifo_rdata;
            count_p0 <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, take})
            2'b10: begin
              tail_p0  <= fifo_rdata;
              count_p0 <= 2'd2;
            end
            2'b01: count_p0 <= 2'd0;
            // Head leaves and the new word replaces it in the same edge.
            2'b11: head_p0 <= fifo_rdata;
            default: ;
          endcase
        end
        2'd2: begin
          // push cannot occur here: fifo_rinc is gated at count 2.
          if (take) begin
            head_p0  <= tail_p0;
            count_p0 <= 2'd1;
          end
        end
        default: count_p0 <= 2'd0;
      endcase
    end
  end

`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] word_cnt_p0;

  // ---- Stage p0: delivered-word counter ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      word_cnt_p0 <= 16'd0;
    end else if (take) begin
      word_cnt_p0 <= sat_inc(word_cnt_p0);
    end
  end

  assign word_cnt = word_cnt_p0;
`endif

endmodule

// File: tb/tb_slink_fifo_rd_stream.sv
module tb_slink_fifo_rd_stream;
  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          reset, enable, flush, fifo_rempty, out_ready;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rinc, out_valid, idle;
  logic [DW-1:0] out_data;
  logic [1:0]    buf_count;
`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
  logic [15:0]   word_cnt;
  int unsigned   m_wcnt = 0;
`endif

  always #5 clk = ~clk;

  slink_fifo_rd_stream #(.DATA_SIZE(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata), .fifo_rinc(fifo_rinc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .buf_count(buf_count), .idle(idle)
`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  // src_q models the upstream FIFO contents; exp_q is the scoreboard of words
  // popped from the FIFO but not yet delivered, in pop order.
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  bit  pop_pend = 1'b0;
  bit  after_reset = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_rempty = (src_q.size() == 0);
    fifo_rdata  = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  task automatic push_src(input logic [DW-1:0] w);
    src_q.push_back(w);
    refresh();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Upstream FIFO: remove the word the DUT popped at this edge.
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      void'(src_q.pop_front());
      refresh();
    end
  end

  // Monitor + reference model, evaluated mid-cycle while everything is stable.
  always @(negedge clk) begin
    bit e_valid, e_rinc, take;
    e_valid = (exp_q.size() != 0);
    e_rinc  = !reset && !flush && enable && (src_q.size() != 0) && (exp_q.size() < 2);
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_valid});
    chk("buf_count", {62'd0, buf_count}, 64'(exp_q.size()));
    chk("fifo_rinc", {63'd0, fifo_rinc}, {63'd0, e_rinc});
    chk("idle", {63'd0, idle}, {63'd0, (exp_q.size() == 0) && (src_q.size() == 0)});
    if (e_valid) chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
    else if (after_reset) chk("out_data_after_reset", {24'd0, out_data}, 64'd0);
`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
    chk("word_cnt", {48'd0, word_cnt}, 64'(m_wcnt));
`endif
    take = e_valid && out_ready;
    pop_pend = 1'b0;
    if (reset) begin
      exp_q.delete();
      after_reset = 1'b1;
`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
      m_wcnt = 0;
`endif
    end else if (flush) begin
      exp_q.delete();
`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
      m_wcnt = 0;
`endif
    end else begin
      if (take) begin
        void'(exp_q.pop_front());
`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
        if (m_wcnt < 65535) m_wcnt++;
`endif
      end
      if (e_rinc) begin
        exp_q.push_back(src_q[0]);
        pop_pend = 1'b1;
        after_reset = 1'b0;
      end
    end
  end

  task automatic drain();
    int k;
    enable = 1; out_ready = 1; flush = 0; reset = 0;
    k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < 100) begin
      cyc(1);
      k++;
    end
    n_chk++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", src_q.size() + exp_q.size());
    end
  endtask

  initial begin
    reset = 1; enable = 1; flush = 0; out_ready = 1;
    refresh();
    cyc(3);

    // Three-word stream at full rate
    reset = 0;
    push_src(40'hA1); push_src(40'hA2); push_src(40'hA3);
    cyc(6);

    // Backpressure: only two pops, head held, then in-order burst
    out_ready = 0;
    for (int i = 0; i < 4; i++) push_src(40'h10 + 40'(i));
    cyc(5);
    chk("bp_buf_count", {62'd0, buf_count}, 64'd2);
    chk("bp_head", {24'd0, out_data}, 64'h10);
    out_ready = 1;
    cyc(6);

    // Flush with two buffered words and a waiting FIFO word
    out_ready = 0;
    push_src(40'h20); push_src(40'h21);
    cyc(3);
    push_src(40'h22);
    flush = 1; out_ready = 1;
    cyc(1);
    flush = 0;
    cyc(4);

    // enable=0 drains without popping, enable=1 resumes
    out_ready = 0;
    push_src(40'h30);
    cyc(2);
    enable = 0;
    push_src(40'h31);
    out_ready = 1;
    cyc(3);
    enable = 1;
    cyc(3);

    // Reset mid-stream with a full buffer
    out_ready = 0;
    push_src(40'h40); push_src(40'h41);
    cyc(3);
    reset = 1;
    cyc(1);
    reset = 0;
    cyc(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      reset     = ($urandom % 200) == 0;
      if (($urandom % 2) == 0 && src_q.size() < 8)
        push_src({8'($urandom), 32'($urandom)});
      cyc(1);
    end
    drain();

`ifdef SLINK_FIFO_RD_STREAM_CNT_EN
    reset = 1; cyc(1); reset = 0;
    for (int i = 0; i < 5; i++) push_src(40'h50 + 40'(i));
    drain();
    chk("cnt_five", {48'd0, word_cnt}, 64'd5);
    flush = 1; cyc(1); flush = 0;
    chk("cnt_flush", {48'd0, word_cnt}, 64'd0);
    for (int i = 0; i < 70010; i++) begin
      if (src_q.size() < 3) push_src(40'(i));
      cyc(1);
    end
    drain();
    chk("cnt_sat", {48'd0, word_cnt}, 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
